// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types for the reservation-station issue scheduler.
// lc3b_rs_id / lc3b_rob_id / lc3b_rs_entry mirror the existing lc3b_types
// definitions so the scheduler and the station agree on entry layout.
// sched_state_e is the scheduler's two-state issue FSM encoding.
package rs_issue_scheduler_pkg;

  typedef logic [1:0] lc3b_rs_id;
  typedef logic [2:0] lc3b_rob_id;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] vj;
    logic [15:0] vk;
    lc3b_rob_id  dest;
    logic [15:0] pc;
  } lc3b_rs_entry;

  typedef enum logic {
    SCHED_EMPTY,
    SCHED_HELD
  } sched_state_e;

endpackage

// File: rtl/rs_issue_scheduler_rr.sv
// rr_arbiter: combinational round-robin pick.
// Returns the first requesting index at or after ptr_i, wrapping modulo SIZE.
// Ports:
//   req_i          request vector, one bit per entry
//   ptr_i          search start index
//   grant_o        granted index (0 when nothing requested)
//   grant_valid_o  at least one request present
module rr_arbiter #(
  parameter int unsigned SIZE = 4,
  localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic [SIZE-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   grant_o,
  output logic            grant_valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      idx = IW'((32'(ptr_i) + i) % SIZE);
      if (!grant_valid_o && req_i[idx]) begin
        grant_o       = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: free-slot allocation plus round-robin issue of ready
// reservation-station entries to a functional unit over a registered
// valid/ack handshake. Accepted entries are released via finish/finish_index.
// Optional build macro: RS_SCHED_PERF_EN enables the stall_count counter;
// without it stall_count is tied to zero.
// Ports:
//   clk, reset_n (async, active-low), flush
//   rs_data / rs_ready / rs_available   station entry contents and flags
//   alloc_index / alloc_full            next free slot for dispatch
//   issue_valid / issue_op / issue_vj / issue_vk / issue_dest / issue_pc
//   issue_ack                           functional unit accepts this cycle
//   finish / finish_index               release the in-flight entry
//   stall_count                         cycles held without ack (perf build)
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  lc3b_rs_entry        rs_data [SIZE],
  input  logic [SIZE-1:0]     rs_ready,
  input  logic [SIZE-1:0]     rs_available,
  output lc3b_rs_id           alloc_index,
  output logic                alloc_full,
  output logic                issue_valid,
  output logic [3:0]          issue_op,
  output logic [15:0]         issue_vj,
  output logic [15:0]         issue_vk,
  output lc3b_rob_id          issue_dest,
  output logic [15:0]         issue_pc,
  input  logic                issue_ack,
  output logic                finish,
  output lc3b_rs_id           finish_index,
  output logic [15:0]         stall_count
);

  sched_state_e    state_q;
  lc3b_rs_entry    entry_q;
  lc3b_rs_id       inflight_q;
  lc3b_rs_id       rr_q;

  logic [SIZE-1:0] cand;
  lc3b_rs_id       grant;
  logic            grant_valid;
  logic            load;
  logic            alloc_found;

  // Lowest available slot.
  always_comb begin
    alloc_index = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!alloc_found && rs_available[i]) begin
        alloc_index = lc3b_rs_id'(i);
        alloc_found = 1'b1;
      end
    end
    alloc_full = ~|rs_available;
  end

  // Ready and busy; the entry already in the issue registers is excluded
  // because the station keeps it busy until the finish edge.
  always_comb begin
    cand = rs_ready & ~rs_available;
    if (state_q == SCHED_HELD) begin
      cand[inflight_q] = 1'b0;
    end
  end

  rr_arbiter #(.SIZE(SIZE)) u_rr (
    .req_i         (cand),
    .ptr_i         (rr_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  assign load = grant_valid && ((state_q == SCHED_EMPTY) || issue_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SCHED_EMPTY;
      entry_q    <= '0;
      inflight_q <= '0;
      rr_q       <= '0;
    end else if (flush) begin
      state_q <= SCHED_EMPTY;
    end else if (load) begin
      entry_q    <= rs_data[grant];
      inflight_q <= grant;
      rr_q       <= lc3b_rs_id'((32'(grant) + 32'd1) % SIZE);
      state_q    <= SCHED_HELD;
    end else if ((state_q == SCHED_HELD) && issue_ack) begin
      state_q <= SCHED_EMPTY;
    end
  end

  assign issue_valid  = (state_q == SCHED_HELD);
  assign issue_op     = entry_q.op;
  assign issue_vj     = entry_q.vj;
  assign issue_vk     = entry_q.vk;
  assign issue_dest   = entry_q.dest;
  assign issue_pc     = entry_q.pc;
  assign finish       = (state_q == SCHED_HELD) && issue_ack && !flush;
  assign finish_index = inflight_q;

`ifdef RS_SCHED_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (issue_valid && !issue_ack && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
module tb_rs_issue_scheduler;
  import rs_issue_scheduler_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         flush;
  lc3b_rs_entry data [4];
  logic [3:0]   rs_ready;
  logic [3:0]   rs_available;
  lc3b_rs_id    alloc_index;
  logic         alloc_full;
  logic         issue_valid;
  logic [3:0]   issue_op;
  logic [15:0]  issue_vj;
  logic [15:0]  issue_vk;
  lc3b_rob_id   issue_dest;
  logic [15:0]  issue_pc;
  logic         issue_ack;
  logic         finish;
  lc3b_rs_id    finish_index;
  logic [15:0]  stall_count;

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];

  typedef struct {
    logic [3:0] avail;
    logic [1:0] idx;
    logic       full;
  } alloc_vec_t;
  alloc_vec_t tbl[9];

  rs_issue_scheduler #(.SIZE(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .rs_data      (data),
    .rs_ready     (rs_ready),
    .rs_available (rs_available),
    .alloc_index  (alloc_index),
    .alloc_full   (alloc_full),
    .issue_valid  (issue_valid),
    .issue_op     (issue_op),
    .issue_vj     (issue_vj),
    .issue_vk     (issue_vk),
    .issue_dest   (issue_dest),
    .issue_pc     (issue_pc),
    .issue_ack    (issue_ack),
    .finish       (finish),
    .finish_index (finish_index),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] payload();
    return 64'({issue_op, issue_vj, issue_vk, issue_dest, issue_pc});
  endfunction

  // Pop the next expected entry from the scoreboard and compare the issue registers.
  task automatic check_issue(input string name);
    int k;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got issue with empty scoreboard expected queued entry", name);
      return;
    end
    k = sb.pop_front();
    chk({name, "_valid"}, 64'(issue_valid), 64'd1);
    chk({name, "_payload"}, payload(), 64'(data[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rr_exp [5];

    data[0] = '{op: 4'h8, vj: 16'h1111, vk: 16'h2222, dest: 3'd0, pc: 16'h3000};
    data[1] = '{op: 4'h9, vj: 16'hA1A1, vk: 16'hB2B2, dest: 3'd5, pc: 16'h3002};
    data[2] = '{op: 4'h1, vj: 16'h0005, vk: 16'h0003, dest: 3'd3, pc: 16'h3004};
    data[3] = '{op: 4'hC, vj: 16'h7E7E, vk: 16'h0F0F, dest: 3'd6, pc: 16'h3006};

    tbl[0] = '{avail: 4'b0000, idx: 2'd0, full: 1'b1};
    tbl[1] = '{avail: 4'b0001, idx: 2'd0, full: 1'b0};
    tbl[2] = '{avail: 4'b0010, idx: 2'd1, full: 1'b0};
    tbl[3] = '{avail: 4'b0100, idx: 2'd2, full: 1'b0};
    tbl[4] = '{avail: 4'b1000, idx: 2'd3, full: 1'b0};
    tbl[5] = '{avail: 4'b1100, idx: 2'd2, full: 1'b0};
    tbl[6] = '{avail: 4'b1010, idx: 2'd1, full: 1'b0};
    tbl[7] = '{avail: 4'b0110, idx: 2'd1, full: 1'b0};
    tbl[8] = '{avail: 4'b1111, idx: 2'd0, full: 1'b0};

    rr_exp[0] = 3'd0; rr_exp[1] = 3'd1; rr_exp[2] = 3'd2; rr_exp[3] = 3'd3; rr_exp[4] = 3'd0;

    reset_n = 1'b0; flush = 1'b0; issue_ack = 1'b0;
    rs_ready = 4'b0000; rs_available = 4'b1111;

    // Reset state
    tick(); tick();
    chk("rst_valid",   64'(issue_valid), 64'd0);
    chk("rst_finish",  64'(finish), 64'd0);
    chk("rst_fidx",    64'(finish_index), 64'd0);
    chk("rst_payload", payload(), 64'd0);
    chk("rst_stall",   64'(stall_count), 64'd0);
    chk("rst_full",    64'(alloc_full), 64'd0);
    reset_n = 1'b1;
    tick();

    // Allocation table (combinational)
    for (int i = 0; i < 9; i++) begin
      rs_available = tbl[i].avail;
      #1;
      chk($sformatf("alloc_idx_%0d", i),  64'(alloc_index), 64'(tbl[i].idx));
      chk($sformatf("alloc_full_%0d", i), 64'(alloc_full),  64'(tbl[i].full));
    end
    tick();

    // Single entry, one-cycle latency, finish on ack, freed slot visible next cycle
    rs_available = 4'b0000; rs_ready = 4'b0100;
    #1;
    chk("single_full", 64'(alloc_full), 64'd1);
    sb.push_back(2);
    tick();
    check_issue("single");
    chk("single_nofinish", 64'(finish), 64'd0);
    issue_ack = 1'b1;
    #1;
    chk("single_finish", 64'(finish), 64'd1);
    chk("single_fidx",   64'(finish_index), 64'd2);
    tick();
    issue_ack = 1'b0; rs_available = 4'b0100; rs_ready = 4'b0000;
    #1;
    chk("freed_idx",   64'(alloc_index), 64'd2);
    chk("freed_full",  64'(alloc_full), 64'd0);
    chk("single_drop", 64'(issue_valid), 64'd0);

    // Stall with ack low, then back-to-back with masking of the in-flight entry
    rs_available = 4'b0000; rs_ready = 4'b0010;
    sb.push_back(1);
    tick();
    check_issue("stall_issue");
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall_finish_%0d", s), 64'(finish), 64'd0);
      chk($sformatf("stall_hold_%0d", s), payload(), 64'(data[1]));
      tick();
    end
    chk("stall_valid", 64'(issue_valid), 64'd1);
`ifdef RS_SCHED_PERF_EN
    chk("stall_count", 64'(stall_count), 64'd5);
`else
    chk("stall_count", 64'(stall_count), 64'd0);
`endif
    issue_ack = 1'b1; rs_ready = 4'b1010;
    #1;
    chk("b2b_finish", 64'(finish), 64'd1);
    chk("b2b_fidx",   64'(finish_index), 64'd1);
    sb.push_back(3);
    tick();
    issue_ack = 1'b0; rs_available = 4'b0010; rs_ready = 4'b1000;
    #1;
    check_issue("b2b_e3");
    issue_ack = 1'b1;
    #1;
    chk("mask_finish", 64'(finish), 64'd1);
    chk("mask_fidx",   64'(finish_index), 64'd3);
    tick();
    issue_ack = 1'b0; rs_available = 4'b1000; rs_ready = 4'b0000;
    #1;
    chk("mask_noreissue", 64'(issue_valid), 64'd0);

    // Flush in the ack cycle
    rs_available = 4'b1110; rs_ready = 4'b0001;
    sb.push_back(0);
    tick();
    check_issue("flush_issue");
    issue_ack = 1'b1; flush = 1'b1;
    #1;
    chk("flush_finish", 64'(finish), 64'd0);
    tick();
    flush = 1'b0; rs_ready = 4'b0000; rs_available = 4'b1111;
    #1;
    chk("flush_valid", 64'(issue_valid), 64'd0);
    chk("empty_ack_ignored", 64'(finish), 64'd0);
    issue_ack = 1'b0;

    // Asynchronous reset mid-handshake
    rs_available = 4'b1011; rs_ready = 4'b0100;
    sb.push_back(2);
    tick();
    check_issue("arst_issue");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(issue_valid), 64'd0);
    chk("arst_stall", 64'(stall_count), 64'd0);
    rs_available = 4'b1111; rs_ready = 4'b0000;
    #1;
    reset_n = 1'b1;
    tick();

    // Round-robin with ack held high: 0,1,2,3,0
    rs_available = 4'b0000; rs_ready = 4'b1111; issue_ack = 1'b1;
    for (int k = 0; k < 5; k++) sb.push_back(int'(rr_exp[k]));
    tick();
    for (int k = 0; k < 5; k++) begin
      check_issue($sformatf("rr_%0d", k));
      chk($sformatf("rr_finish_%0d", k), 64'(finish), 64'd1);
      chk($sformatf("rr_fidx_%0d", k), 64'(finish_index), 64'(rr_exp[k]));
      tick();
    end
    issue_ack = 1'b0; rs_ready = 4'b0000; rs_available = 4'b1111;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Issue scheduler for one reservation station: picks a free slot for the dispatch stage to load, selects one ready entry per cycle by round-robin, and presents it to the functional unit through a registered valid/ack handshake. On acceptance it pulses the station's finish/finish_index to release the slot. It sits between the reservation station outputs and the functional unit input; flush is shared with the station.

## Interface
- SIZE, 4, number of reservation station entries; must match the station
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; same signal driven to the station
- rs_data  in  lc3b_rs_entry[SIZE]  station entry contents
- rs_ready  in  SIZE  per-entry operands-ready flags
- rs_available  in  SIZE  per-entry not-busy flags
- alloc_index  out  lc3b_rs_id  slot dispatch loads next
- alloc_full  out  1  no free slot; dispatch must stall
- issue_valid  out  1  issue registers hold a valid instruction
- issue_op  out  4  opcode of the issued entry
- issue_vj, issue_vk  out  16 each  operand values
- issue_dest  out  lc3b_rob_id  ROB tag for the result
- issue_pc  out  16  PC of the issued entry
- issue_ack  in  1  functional unit accepts the issue registers this cycle
- finish  out  1  release the in-flight entry (to station finish)
- finish_index  out  lc3b_rs_id  entry to release
- stall_count  out  16  only with RS_SCHED_PERF_EN

## Operation
- Allocation (combinational): alloc_index is the lowest index with rs_available set. alloc_full = no bit set; alloc_index = 0 when full.
- State: issue_valid, inflight_idx, issue payload registers, rr_ptr (lc3b_rs_id).
- Two states, EMPTY (issue_valid=0) and HELD (issue_valid=1).
- Candidate mask = rs_ready & ~rs_available-inverted-busy qualifiers, i.e. ready and busy. In HELD, bit inflight_idx is also masked.
- Grant: first candidate at or after rr_ptr, wrapping modulo SIZE.
- EMPTY: any candidate, so load payload from rs_data[grant], set inflight_idx=grant and rr_ptr=(grant+1) mod SIZE, then go to HELD. Otherwise stay in EMPTY.
- HELD, issue_ack=0: payload and inflight_idx held stable; no grant.
- HELD, issue_ack=1: finish=1 and finish_index=inflight_idx, combinationally in the same cycle. If a candidate exists, load it and stay in HELD (back-to-back). Otherwise go to EMPTY.
- finish=0 in every other case; finish_index = inflight_idx always.
- flush=1 overrides everything: issue_valid←0, finish forced 0, no grant. rr_ptr is unchanged.
- issue_ack is ignored while issue_valid=0.

## Timing
- Reset: issue_valid=0, inflight_idx=0, payload=0, rr_ptr=0, stall_count=0. Derived outputs: finish=0, alloc_full reflects rs_available.
- Reset is asynchronous. Assertion mid-handshake drops issue_valid immediately; the station is flushed separately.
- Latency: entry ready in cycle N with the scheduler in EMPTY means issue_valid=1 in cycle N+1.
- Throughput: one issue per cycle while issue_ack is held high and candidates exist.
- Finish and the station's busy clear take effect at the edge ending the ack cycle. The freed slot appears in alloc_index the following cycle.
- Ack and flush in the same cycle: flush wins, and no finish is generated.

## Configuration
- RS_SCHED_PERF_EN defined: stall_count increments on every cycle with issue_valid=1 and issue_ack=0. It saturates at 16'hFFFF and is cleared only by reset.
- RS_SCHED_PERF_EN undefined: the stall_count port is present but tied to 0, and no counter logic is built.

## Structure
- lc3b_types: lc3b_rs_id, lc3b_rs_entry, and lc3b_rob_id, all existing; add no new types.
- Sub-module rr_arbiter (parameter SIZE): request vector plus pointer in, grant index and grant_valid out. Purely combinational.
- All state lives in rs_issue_scheduler.

## Test plan
- Single entry: rs_ready=0100 with busy entry 2 (op=4'h1, vj=16'h0005, vk=16'h0003, dest=3). Expect issue_valid next cycle with those values. Ack one cycle later gives finish=1, finish_index=2.
- Round-robin: rs_ready=1111, ack held high. Expect issue order 0,1,2,3,0 with rr_ptr wrapping from 3 to 0.
- Stall: issue held for 5 cycles with ack=0. Payload must stay constant and finish=0. With the perf macro, stall_count=5.
- Back-to-back with masking: entry 1 in flight with ack=0 while rs_ready=0010. No reissue of entry 1. On ack, with entry 3 newly ready, entry 3 issues the next cycle.
- Flush in the ack cycle: issue_valid=1, ack=1, flush=1. Expect finish=0, and issue_valid=0 next cycle.
- Allocation: rs_available=0000 gives alloc_full=1. After a finish of index 2, the next cycle shows alloc_index=2 and alloc_full=0.
